// File: rtl/ysyx_idu_pkg.sv
// ysyx_idu_pkg: shared definitions for the decode stage.
//   - RV32I major opcodes, ALU operation codes, immediate formats
//   - ctrl_o bit positions and the decoded-bundle struct
//   - skid-buffer occupancy states
package ysyx_idu_pkg;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
   } imm_type_e;

   localparam int CTRL_W       = 12;
   localparam int CTRL_LOAD    = 0;
   localparam int CTRL_STORE   = 1;
   localparam int CTRL_BRANCH  = 2;
   localparam int CTRL_JAL     = 3;
   localparam int CTRL_JALR    = 4;
   localparam int CTRL_LUI     = 5;
   localparam int CTRL_AUIPC   = 6;
   localparam int CTRL_CSR     = 7;
   localparam int CTRL_ECALL   = 8;
   localparam int CTRL_EBREAK  = 9;
   localparam int CTRL_MRET    = 10;
   localparam int CTRL_FENCE_I = 11;

   typedef struct packed {
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [31:0]       imm;
      alu_op_e           alu_op;
      logic [CTRL_W-1:0] ctrl;
      logic [2:0]        funct3;
      logic              illegal;
   } dec_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e imm_type);
      case (imm_type)
         IMM_I:   return {{20{inst[31]}}, inst[31:20]};
         IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   return {inst[31:12], 12'b0};
         IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   // alt selects SUB over ADD and SRA over SRL (inst[30] on register ops)
   function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_idu_dec.sv
// ysyx_idu_dec: purely combinational RV32I + Zicsr/Zifencei + mret decoder.
//   inst : fetched instruction word
//   dec  : decoded bundle (register indices, immediate, ALU op, class flags,
//          raw funct3, illegal flag)
module ysyx_idu_dec
   import ysyx_idu_pkg::*;
(
   input  logic [31:0] inst,
   output dec_t        dec
);

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   imm_type_e         imm_type;
   logic              use_rd;
   logic              use_rs1;
   logic              use_rs2;
   alu_op_e           alu_op;
   logic [CTRL_W-1:0] ctrl;
   logic              illegal;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Any inst[1:0] other than 2'b11 cannot match a supported opcode, so the
   // default branch also covers compressed/reserved encodings.
   always_comb begin
      imm_type = IMM_NONE;
      use_rd   = 1'b0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      alu_op   = ALU_ADD;
      ctrl     = '0;
      illegal  = 1'b0;
      case (opcode)
         OPC_LUI: begin
            use_rd = 1'b1; imm_type = IMM_U; alu_op = ALU_PASS_B;
            ctrl[CTRL_LUI] = 1'b1;
         end
         OPC_AUIPC: begin
            use_rd = 1'b1; imm_type = IMM_U;
            ctrl[CTRL_AUIPC] = 1'b1;
         end
         OPC_JAL: begin
            use_rd = 1'b1; imm_type = IMM_J;
            ctrl[CTRL_JAL] = 1'b1;
         end
         OPC_JALR: begin
            use_rd = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I;
            ctrl[CTRL_JALR] = 1'b1;
         end
         OPC_BRANCH: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_B; alu_op = ALU_SUB;
            ctrl[CTRL_BRANCH] = 1'b1;
         end
         OPC_LOAD: begin
            use_rd = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I;
            ctrl[CTRL_LOAD] = 1'b1;
         end
         OPC_STORE: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_S;
            ctrl[CTRL_STORE] = 1'b1;
         end
         OPC_OP_IMM: begin
            use_rd = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I;
            // inst[30] is immediate data for ADDI; it only selects SRAI
            alu_op = alu_from_funct3(funct3, inst[30] && (funct3 == 3'b101));
         end
         OPC_OP: begin
            use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            alu_op = alu_from_funct3(funct3, inst[30]);
            if (funct7 != 7'h00 && funct7 != 7'h20)
               illegal = 1'b1;
            else if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
               illegal = 1'b1;
         end
         OPC_MISC_MEM: begin
            use_rd = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I;
            ctrl[CTRL_FENCE_I] = (funct3 == 3'b001);
         end
         OPC_SYSTEM: begin
            use_rd = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I; alu_op = ALU_PASS_B;
            if (funct3 != 3'b000) begin
               ctrl[CTRL_CSR] = 1'b1;
            end else begin
               case (inst[31:20])
                  12'h000: ctrl[CTRL_ECALL]  = 1'b1;
                  12'h001: ctrl[CTRL_EBREAK] = 1'b1;
                  12'h302: ctrl[CTRL_MRET]   = 1'b1;
                  default: illegal = 1'b1;
               endcase
            end
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) ctrl = '0;
   end

   always_comb begin
      dec.rd      = use_rd  ? inst[11:7]  : 5'd0;
      dec.rs1     = use_rs1 ? inst[19:15] : 5'd0;
      dec.rs2     = use_rs2 ? inst[24:20] : 5'd0;
      dec.imm     = imm_gen(inst, imm_type);
      dec.alu_op  = alu_op;
      dec.ctrl    = ctrl;
      dec.funct3  = funct3;
      dec.illegal = illegal;
   end

endmodule

// File: rtl/ysyx_idu_skid.sv
// ysyx_idu_skid: decode stage with a 2-entry skid buffer between fetch and
// execute. ready_o is a function of registered state only, so execute-stage
// backpressure never reaches fetch combinationally.
//   clk, rst (async, active-low)
//   prev_valid / ready_o / inst_i / pc_i : fetch-side handshake and payload
//   flush                                : redirect, drops everything buffered
//   valid_o / next_ready                 : execute-side handshake
//   pc_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o, ctrl_o, funct3_o, illegal_o
//                                        : decoded bundle, always from main
//
// state     | meaning
// BUF_EMPTY | no bundle held, valid_o=0
// BUF_ONE   | main entry holds the output bundle
// BUF_FULL  | main + skid both hold bundles, ready_o=0
module ysyx_idu_skid
   import ysyx_idu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prev_valid,
   output logic               ready_o,
   input  logic [DATA_W-1:0]  inst_i,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic               flush,
   output logic               valid_o,
   input  logic               next_ready,
   output logic [ADDR_W-1:0]  pc_o,
   output logic [4:0]         rd_o,
   output logic [4:0]         rs1_o,
   output logic [4:0]         rs2_o,
   output logic [DATA_W-1:0]  imm_o,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic [11:0]        ctrl_o,
   output logic [2:0]         funct3_o,
   output logic               illegal_o
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      dec_t              dec;
   } entry_t;

   buf_state_e state_q;
   buf_state_e state_d;
   entry_t     main_q;
   entry_t     skid_q;
   entry_t     new_e;
   dec_t       dec_new;
   logic       accept;
   logic       emit;
   logic       ld_main_new;
   logic       ld_main_skid;
   logic       ld_skid;

   ysyx_idu_dec u_dec (
      .inst (inst_i),
      .dec  (dec_new)
   );

   assign new_e.pc  = pc_i;
   assign new_e.dec = dec_new;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= BUF_EMPTY;
      else      state_q <= state_d;
   end

   // Load enables are produced alongside the next state so the datapath
   // always follows the same transition the FSM takes.
   always_comb begin
      state_d      = state_q;
      ld_main_new  = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         state_d = BUF_EMPTY;
      end else begin
         case (state_q)
            BUF_EMPTY: begin
               if (accept) begin
                  state_d     = BUF_ONE;
                  ld_main_new = 1'b1;
               end
            end
            BUF_ONE: begin
               if (accept && emit) begin
                  ld_main_new = 1'b1;
               end else if (accept) begin
                  state_d = BUF_FULL;
                  ld_skid = 1'b1;
               end else if (emit) begin
                  state_d = BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (emit) begin
                  state_d      = BUF_ONE;
                  ld_main_skid = 1'b1;
               end
            end
            default: state_d = BUF_EMPTY;
         endcase
      end
   end

   always_comb begin
      valid_o = (state_q != BUF_EMPTY);
      ready_o = (state_q != BUF_FULL);
      accept  = prev_valid && ready_o;
      emit    = valid_o && next_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (ld_main_new)       main_q <= new_e;
         else if (ld_main_skid) main_q <= skid_q;
         if (ld_skid)           skid_q <= new_e;
      end
   end

   assign pc_o      = main_q.pc;
   assign rd_o      = main_q.dec.rd;
   assign rs1_o     = main_q.dec.rs1;
   assign rs2_o     = main_q.dec.rs2;
   assign imm_o     = main_q.dec.imm;
   assign alu_op_o  = main_q.dec.alu_op;
   assign ctrl_o    = main_q.dec.ctrl;
   assign funct3_o  = main_q.dec.funct3;
   assign illegal_o = main_q.dec.illegal;

endmodule

// File: tb/tb_ysyx_idu_skid.sv
// Bench for ysyx_idu_skid: a queue-based model of the buffer plus a reference
// decoder, checked every negative clock edge, and hand-computed pins.
module tb_ysyx_idu_skid;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        prev_valid = 1'b0;
   logic        ready_o;
   logic [31:0] inst_i = '0;
   logic [31:0] pc_i = '0;
   logic        flush = 1'b0;
   logic        valid_o;
   logic        next_ready = 1'b0;
   logic [31:0] pc_o;
   logic [4:0]  rd_o, rs1_o, rs2_o;
   logic [31:0] imm_o;
   logic [3:0]  alu_op_o;
   logic [11:0] ctrl_o;
   logic [2:0]  funct3_o;
   logic        illegal_o;

   always #5 clk = ~clk;

   ysyx_idu_skid dut (
      .clk        (clk),
      .rst        (rst),
      .prev_valid (prev_valid),
      .ready_o    (ready_o),
      .inst_i     (inst_i),
      .pc_i       (pc_i),
      .flush      (flush),
      .valid_o    (valid_o),
      .next_ready (next_ready),
      .pc_o       (pc_o),
      .rd_o       (rd_o),
      .rs1_o      (rs1_o),
      .rs2_o      (rs2_o),
      .imm_o      (imm_o),
      .alu_op_o   (alu_op_o),
      .ctrl_o     (ctrl_o),
      .funct3_o   (funct3_o),
      .illegal_o  (illegal_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [11:0] ctrl;
      logic [2:0]  f3;
      logic        ill;
   } exp_t;

   // Reference decode straight from the ISA rules.
   function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] p);
      exp_t        e;
      int          alu_tab[8];
      logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
      f3 = w[14:12];
      f7 = w[31:25];
      i_imm = {{20{w[31]}}, w[31:20]};
      s_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      u_imm = {w[31:12], 12'h000};
      j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      e.pc = p; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0;
      e.alu = 0; e.ctrl = 0; e.f3 = f3; e.ill = 0;
      case (w[6:0])
         7'h37: begin e.rd = w[11:7]; e.imm = u_imm; e.alu = 10; e.ctrl[5] = 1; end
         7'h17: begin e.rd = w[11:7]; e.imm = u_imm; e.ctrl[6] = 1; end
         7'h6F: begin e.rd = w[11:7]; e.imm = j_imm; e.ctrl[3] = 1; end
         7'h67: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm; e.ctrl[4] = 1; end
         7'h63: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = b_imm; e.alu = 1; e.ctrl[2] = 1; end
         7'h03: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm; e.ctrl[0] = 1; end
         7'h23: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = s_imm; e.ctrl[1] = 1; end
         7'h13: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm;
            e.alu = 4'(alu_tab[f3] + ((f3 == 5 && w[30]) ? 1 : 0));
         end
         7'h33: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.alu = 4'(alu_tab[f3] + (((f3 == 5 || f3 == 0) && w[30]) ? 1 : 0));
            e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
         end
         7'h0F: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm; e.ctrl[11] = (f3 == 1); end
         7'h73: begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm; e.alu = 10;
            if (f3 != 0)                 e.ctrl[7] = 1;
            else if (w[31:20] == 12'h000) e.ctrl[8] = 1;
            else if (w[31:20] == 12'h001) e.ctrl[9] = 1;
            else if (w[31:20] == 12'h302) e.ctrl[10] = 1;
            else                          e.ill = 1;
         end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   // Buffer model: a FIFO of at most two bundles.
   exp_t q[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
      end else begin
         bit acc, emt;
         acc = prev_valid && (q.size() < 2);
         emt = (q.size() > 0) && next_ready;
         if (emt) void'(q.pop_front());
         if (flush)    q.delete();
         else if (acc) q.push_back(ref_dec(inst_i, pc_i));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("m_valid", valid_o, q.size() != 0);
         chk("m_ready", ready_o, q.size() < 2);
         if (q.size() != 0) begin
            chk("m_pc",      pc_o,      q[0].pc);
            chk("m_rd",      rd_o,      q[0].rd);
            chk("m_rs1",     rs1_o,     q[0].rs1);
            chk("m_rs2",     rs2_o,     q[0].rs2);
            chk("m_imm",     imm_o,     q[0].imm);
            chk("m_alu",     alu_op_o,  q[0].alu);
            chk("m_ctrl",    ctrl_o,    q[0].ctrl);
            chk("m_funct3",  funct3_o,  q[0].f3);
            chk("m_illegal", illegal_o, q[0].ill);
         end
      end
   end

   task automatic cyc(input logic pv, input logic [31:0] ins, input logic [31:0] p,
                      input logic nr, input logic fl);
      prev_valid = pv; inst_i = ins; pc_i = p; next_ready = nr; flush = fl;
      @(posedge clk);
      #2;
   endtask

   // Present like fetch does: hold until accepted (retries let execute drain).
   task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic nr);
      int   n;
      logic took;
      n = 0;
      do begin
         took = ready_o;
         cyc(1'b1, ins, p, (n == 0) ? nr : 1'b1, 1'b0);
         n++;
      end while (!took && n < 20);
      if (!took) chk("send_timeout", 1'b0, 1'b1);
   endtask

   localparam logic [31:0] ADDI   = 32'h00500093;
   localparam logic [31:0] BEQ    = 32'hFE000EE3;
   localparam logic [31:0] MRET   = 32'h30200073;
   localparam logic [31:0] ADD_I  = 32'h002081B3;
   localparam logic [31:0] SUB_I  = 32'h402081B3;
   localparam logic [31:0] LUI_I  = 32'h123450B7;

   logic [31:0] vec[10];

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vec = '{32'h0020A423, 32'h010000EF, 32'h0040A103, 32'h34029073, 32'h4030D093,
              32'h022081B3, 32'h4020A1B3, 32'h0000100F, 32'h00100073, 32'hFFC08067};

      #2;
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_imm", imm_o, 32'h0);
      chk("rst_ctrl", ctrl_o, 12'h0);
      chk("rst_rd", rd_o, 5'd0);
      #6 rst = 1'b1;

      // addi x1,x0,5
      cyc(1'b1, ADDI, 32'h80000000, 1'b1, 1'b0);
      chk("addi_valid", valid_o, 1'b1);
      chk("addi_pc", pc_o, 32'h80000000);
      chk("addi_rd", rd_o, 5'd1);
      chk("addi_rs1", rs1_o, 5'd0);
      chk("addi_imm", imm_o, 32'd5);
      chk("addi_alu", alu_op_o, 4'd0);
      chk("addi_illegal", illegal_o, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("addi_drain", valid_o, 1'b0);

      // beq x0,x0,-4
      cyc(1'b1, BEQ, 32'h80000004, 1'b1, 1'b0);
      chk("beq_imm", imm_o, 32'hFFFFFFFC);
      chk("beq_branch", ctrl_o[2], 1'b1);
      chk("beq_rd", rd_o, 5'd0);

      // illegal zero word then mret, streamed back to back
      cyc(1'b1, 32'h0, 32'h80000008, 1'b1, 1'b0);
      chk("zero_illegal", illegal_o, 1'b1);
      chk("zero_ctrl", ctrl_o, 12'h0);
      cyc(1'b1, MRET, 32'h8000000C, 1'b1, 1'b0);
      chk("mret_ctrl", ctrl_o[10], 1'b1);
      chk("mret_illegal", illegal_o, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // backpressure: three back to back with execute stalled
      cyc(1'b1, ADD_I, 32'h100, 1'b0, 1'b0);
      chk("bp1_pc", pc_o, 32'h100);
      chk("bp1_ready", ready_o, 1'b1);
      cyc(1'b1, SUB_I, 32'h104, 1'b0, 1'b0);
      chk("bp2_ready", ready_o, 1'b0);
      chk("bp2_pc", pc_o, 32'h100);
      cyc(1'b1, LUI_I, 32'h108, 1'b0, 1'b0);
      chk("bp3_held_pc", pc_o, 32'h100);
      chk("bp3_ready", ready_o, 1'b0);
      cyc(1'b1, LUI_I, 32'h108, 1'b1, 1'b0);
      chk("bp_out2_pc", pc_o, 32'h104);
      chk("bp_out2_alu", alu_op_o, 4'd1);
      cyc(1'b1, LUI_I, 32'h108, 1'b1, 1'b0);
      chk("bp_out3_pc", pc_o, 32'h108);
      chk("bp_out3_imm", imm_o, 32'h12345000);
      chk("bp_out3_rs1", rs1_o, 5'd0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("bp_empty", valid_o, 1'b0);

      // flush while FULL, then flush racing an accept
      cyc(1'b1, ADD_I, 32'h200, 1'b0, 1'b0);
      cyc(1'b1, SUB_I, 32'h204, 1'b0, 1'b0);
      chk("fl_full_ready", ready_o, 1'b0);
      cyc(1'b1, LUI_I, 32'h208, 1'b0, 1'b1);
      chk("fl_valid", valid_o, 1'b0);
      chk("fl_ready", ready_o, 1'b1);
      cyc(1'b1, MRET, 32'h20C, 1'b1, 1'b1);
      chk("fl_drop_valid", valid_o, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fl_drop_valid2", valid_o, 1'b0);

      // asynchronous reset mid-cycle while FULL
      cyc(1'b1, ADD_I, 32'h300, 1'b0, 1'b0);
      cyc(1'b1, SUB_I, 32'h304, 1'b0, 1'b0);
      prev_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", valid_o, 1'b0);
      chk("arst_ready", ready_o, 1'b1);
      chk("arst_pc", pc_o, 32'h0);
      @(posedge clk);
      #3 rst = 1'b1;
      send(32'h00A00113, 32'h400, 1'b1);
      chk("post_rst_valid", valid_o, 1'b1);
      chk("post_rst_rd", rd_o, 5'd2);
      chk("post_rst_imm", imm_o, 32'd10);
      chk("post_rst_pc", pc_o, 32'h400);

      // mixed stream with intermittent stalls, checked by the model
      for (int i = 0; i < 10; i++)
         send(vec[i], 32'h500 + 32'(i * 4), (i % 3) != 2);
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("end_empty", valid_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_idu_skid.md
Name: ysyx_idu_skid

Overview:
- Decode stage directly downstream of the instruction fetch unit.
- Accepts one fetched instruction (inst, pc) per valid/ready handshake and decodes it as RV32I plus Zicsr/Zifencei and mret.
- Holds the decoded bundle in a 2-entry skid buffer, so fetch is never throttled combinationally by execute-stage backpressure.
- Supports a redirect flush from the branch/writeback path.

Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, instruction/data width
- ALUOP_W, 4, width of ALU operation code

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- prev_valid  in  1  fetch has valid inst_i/pc_i
- ready_o  out  1  block can accept (drives the fetch unit's next_ready)
- inst_i  in  DATA_W  fetched instruction
- pc_i  in  ADDR_W  PC of inst_i
- flush  in  1  redirect; discard all buffered and incoming instructions
- valid_o  out  1  decoded bundle valid
- next_ready  in  1  execute stage accepts the bundle
- pc_o  out  ADDR_W  PC of the bundle
- rd_o, rs1_o, rs2_o  out  5 each  register indices
- imm_o  out  DATA_W  sign-extended immediate
- alu_op_o  out  ALUOP_W  ALU operation
- ctrl_o  out  12  one-hot-ish class flags: load, store, branch, jal, jalr, lui, auipc, csr, ecall, ebreak, mret, fence_i
- funct3_o  out  3  raw funct3
- illegal_o  out  1  unrecognised encoding

Behaviour:
- Reset (rst=0, asynchronous):
  - main and skid entries invalid; valid_o=0, ready_o=1.
  - All data outputs are 0; datapath registers are also cleared.
- Handshakes:
  - Accept when prev_valid & ready_o; emit when valid_o & next_ready.
- Latency:
  - Decode is combinational on inst_i and captured at accept.
  - A bundle accepted at edge N is visible on the outputs after edge N, with no bubble when the main entry is empty or draining.
- Buffer states: EMPTY (no entries), ONE (main only), FULL (main+skid).
  - ready_o = !skid_valid, registered; never depends combinationally on next_ready.
  - EMPTY + accept -> ONE (load main).
  - ONE + accept + emit -> ONE (main <= new).
  - ONE + accept + no emit -> FULL (skid <= new).
  - ONE + emit + no accept -> EMPTY.
  - FULL + emit -> ONE (main <= skid). Accept is impossible in FULL since ready_o=0.
  - FULL + no emit -> FULL, all outputs held stable.
- Outputs are always driven from main.
- Flush:
  - Next state is EMPTY regardless of other inputs.
  - An accept in the same cycle is dropped; the fetch unit treats it as consumed.
  - An emit in the same cycle still completes, because execute sampled it.
- Immediate formats (all sign bits from inst[31]):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Illegal encodings:
  - illegal_o=1 for: opcode not in the supported set; funct7 not 0x00/0x20 on OP; SUB/SRA pattern on a non-ADD/SR funct3; inst[1:0]!=2'b11.
  - An illegal instruction still flows through as a bundle with all ctrl_o bits 0; the trap decision is made downstream.
- Register indices for formats lacking a field (U/J have no rs1/rs2; S/B have no rd) output 0.

Decomposition:
- Package ysyx_idu_pkg:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM)
  - ALU op encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B)
  - immediate-type enum (I, S, B, U, J, NONE)
  - ctrl bit indices
- One combinational sub-module, ysyx_idu_dec (inst in, decoded bundle out).
- ysyx_idu_skid holds only the buffer FSM and registers.

Test Plan:
- Input 0x00500093 (addi x1,x0,5) at pc 0x80000000, next_ready=1:
  - one cycle later valid_o=1, rd_o=1, rs1_o=0, imm_o=5, alu_op_o=ADD, illegal_o=0.
  - next cycle valid_o=0.
- Input 0xFE000EE3 (beq x0,x0,-4):
  - imm_o=0xFFFFFFFC, ctrl_o.branch=1, rd_o=0.
- Backpressure:
  - next_ready=0, present 3 instructions back to back: first two accepted, ready_o=0 after the second, third held by upstream.
  - Raise next_ready: bundles emerge in order on consecutive cycles, with no loss or duplication.
- Flush while FULL:
  - valid_o=0 and ready_o=1 the next cycle.
  - An instruction presented during the flush cycle never appears on the output.
- Input 0x00000000 -> illegal_o=1, ctrl_o=0. Input 0x30200073 (mret) -> ctrl_o.mret=1, illegal_o=0.
- Assert rst=0 asynchronously mid-cycle while FULL:
  - valid_o=0 and ready_o=1 immediately, without waiting for a clock edge.
  - The first instruction after release decodes correctly.
